// File: rtl/reset_conditioner.sv
// Board reset conditioner for the SOC: synchronises and debounces the pushbutton,
// stretches every reset cause to a minimum length and counts button-triggered resets.
module reset_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int RESET_HOLD_CYCLES = 1024,
    parameter int SYNC_STAGES       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button_i,
    output logic       soc_rst_n,
    output logic       button_pressed,
    output logic [7:0] reset_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUTTON = 2'd2
    } state_e;

    logic [1:0]             rst_sync_q;
    logic                   rst_sync_n;
    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic                   btn_s;

    logic [DB_W-1:0]        db_cnt_q;
    logic [DB_W-1:0]        db_cnt_d;
    logic                   btn_db_q;
    logic                   btn_db_d;
    logic                   db_rise;
    logic                   db_fall;

    state_e                 state_q;
    logic [HOLD_W-1:0]      hold_cnt_q;
    logic                   soc_rst_n_q;
    logic                   button_pressed_q;
    logic [7:0]             reset_count_q;

    // Release of the board reset is only seen by the hold counter after two clean flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync_q <= '0;
        end else begin
            btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], button_i};
        end
    end

    assign btn_s = btn_sync_q[SYNC_STAGES-1];

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        db_cnt_d = db_cnt_q;
        btn_db_d = btn_db_q;
        db_rise  = 1'b0;
        db_fall  = 1'b0;
        if (btn_s == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d = '0;
            btn_db_d = btn_s;
            db_rise  = btn_s;
            db_fall  = !btn_s;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q         <= '0;
            btn_db_q         <= 1'b0;
            button_pressed_q <= 1'b0;
        end else begin
            db_cnt_q         <= db_cnt_d;
            btn_db_q         <= btn_db_d;
            button_pressed_q <= db_rise;
        end
    end

    // Debounced edges act on the same clock edge that btn_db changes, so the
    // press pulse and the falling soc_rst_n coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            soc_rst_n_q   <= 1'b0;
            reset_count_q <= '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (db_rise) begin
                        state_q     <= ST_BUTTON;
                        hold_cnt_q  <= '0;
                        soc_rst_n_q <= 1'b0;
                        if (reset_count_q != 8'hFF) begin
                            reset_count_q <= reset_count_q + 8'd1;
                        end
                    end else if (rst_sync_n) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_q     <= ST_RUN;
                            hold_cnt_q  <= '0;
                            soc_rst_n_q <= 1'b1;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (db_rise) begin
                        state_q     <= ST_BUTTON;
                        soc_rst_n_q <= 1'b0;
                        if (reset_count_q != 8'hFF) begin
                            reset_count_q <= reset_count_q + 8'd1;
                        end
                    end
                end
                ST_BUTTON: begin
                    soc_rst_n_q <= 1'b0;
                    if (db_fall) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q     <= ST_HOLD;
                    hold_cnt_q  <= '0;
                    soc_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign soc_rst_n      = soc_rst_n_q;
    assign button_pressed = button_pressed_q;
    assign reset_count    = reset_count_q;

endmodule

// File: tb/tb_reset_conditioner.sv
// Directed bench for reset_conditioner with short debounce/hold lengths:
// a per-cycle vector table for power-on, glitch and press sequences, plus hand-written corner cases.
module tb_reset_conditioner;

    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       button = 1'b0;
    logic       soc;
    logic       pressed;
    logic [7:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       btn;
        logic       expSoc;
        logic       expPressed;
        logic [7:0] expCount;
    } vec_t;

    vec_t vecs[$];

    reset_conditioner #(
        .DEBOUNCE_CYCLES  (DB),
        .RESET_HOLD_CYCLES(HOLD),
        .SYNC_STAGES      (SYNC)
    ) dut (
        .clk           (clk),
        .rst_n         (rstN),
        .button_i      (button),
        .soc_rst_n     (soc),
        .button_pressed(pressed),
        .reset_count   (count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic void addVec(input logic btn, input int n, input logic expSoc,
                                   input logic expPressed, input logic [7:0] expCount);
        vec_t v;
        v.btn        = btn;
        v.expSoc     = expSoc;
        v.expPressed = expPressed;
        v.expCount   = expCount;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    // Vector k is driven before edge k+1 (edge 1 = first edge after reset release) and sampled after it.
    task automatic applyStimulus(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            button = vecs[i].btn;
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s_soc_e%0d", tag, i + 1), 32'(soc), 32'(vecs[i].expSoc));
            checkOutput($sformatf("%s_pressed_e%0d", tag, i + 1), 32'(pressed), 32'(vecs[i].expPressed));
            checkOutput($sformatf("%s_count_e%0d", tag, i + 1), 32'(count), 32'(vecs[i].expCount));
        end
        vecs.delete();
    endtask

    initial begin
        logic seen;

        // Power-on: reset held for 5 cycles, released between edges.
        rstN   = 1'b0;
        button = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset_soc", 32'(soc), 32'd0);
        checkOutput("reset_pressed", 32'(pressed), 32'd0);
        checkOutput("reset_count", 32'(count), 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        // Power-on timing: low through edge 9, high from edge 10.
        addVec(1'b0, 9, 1'b0, 1'b0, 8'd0);
        addVec(1'b0, 3, 1'b1, 1'b0, 8'd0);
        // 3-cycle glitch at edges 13..15 is rejected.
        addVec(1'b1, 3, 1'b1, 1'b0, 8'd0);
        addVec(1'b0, 5, 1'b1, 1'b0, 8'd0);
        // Clean press edges 21..40: accepted at 26, release at 41 -> RUN at 54.
        addVec(1'b1, 5, 1'b1, 1'b0, 8'd0);
        addVec(1'b1, 1, 1'b0, 1'b1, 8'd1);
        addVec(1'b1, 14, 1'b0, 1'b0, 8'd1);
        addVec(1'b0, 13, 1'b0, 1'b0, 8'd1);
        addVec(1'b0, 3, 1'b1, 1'b0, 8'd1);
        // Second press from 57: accepted at 62, release 77, btn_db falls at 82 (HOLD).
        addVec(1'b1, 5, 1'b1, 1'b0, 8'd1);
        addVec(1'b1, 1, 1'b0, 1'b1, 8'd2);
        addVec(1'b1, 14, 1'b0, 1'b0, 8'd2);
        addVec(1'b0, 4, 1'b0, 1'b0, 8'd2);
        // Re-press from 81: rises at 86, three cycles into HOLD; release 96 -> RUN at 109.
        addVec(1'b1, 5, 1'b0, 1'b0, 8'd2);
        addVec(1'b1, 1, 1'b0, 1'b1, 8'd3);
        addVec(1'b1, 9, 1'b0, 1'b0, 8'd3);
        addVec(1'b0, 13, 1'b0, 1'b0, 8'd3);
        addVec(1'b0, 3, 1'b1, 1'b0, 8'd3);
        applyStimulus("seq");

        // Asynchronous reset while in BUTTON.
        button = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (!soc) seen = 1'b1;
        end
        checkOutput("async_enter_button", 32'(seen), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("async_pre_count", 32'(count), 32'd4);
        @(negedge clk);
        rstN   = 1'b0;
        button = 1'b0;
        #1;
        checkOutput("async_soc_now", 32'(soc), 32'd0);
        checkOutput("async_count_now", 32'(count), 32'd0);
        checkOutput("async_pressed_now", 32'(pressed), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("repower_soc_e%0d", e), 32'(soc), (e >= 2 + HOLD) ? 32'd1 : 32'd0);
            checkOutput($sformatf("repower_count_e%0d", e), 32'(count), 32'd0);
        end

        // Saturation: 300 presses, each 6 cycles high then 6 low.
        for (int k = 1; k <= 300; k++) begin
            button = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            checkOutput($sformatf("sat_count_%0d", k), 32'(count), (k > 255) ? 32'd255 : 32'(k));
            checkOutput($sformatf("sat_pulse_%0d", k), 32'(pressed), 32'd1);
            button = 1'b0;
            repeat (6) @(posedge clk);
            #1;
        end
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (soc) seen = 1'b1;
        end
        checkOutput("sat_final_run", 32'(seen), 32'd1);
        checkOutput("sat_final_count", 32'(count), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_conditioner.md
Name: reset_conditioner

Overview:
- Sits between the board reset/pushbutton pins and the Grande_Risco_5_SOC `rst_n` input on the FPGA top level.
- Synchronises and debounces a raw pushbutton and stretches every reset to a guaranteed minimum length.
- Drives the SOC reset: assertion is asynchronous, deassertion is synchronous to `clk`, so the SOC, caches and UART always leave reset cleanly on a clock edge.
- Counts button-triggered resets for debug.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz). Must be >= 1.
- RESET_HOLD_CYCLES, 1024: minimum cycles `soc_rst_n` stays low after every reset cause ends. Must be >= 1.
- SYNC_STAGES, 2: flop depth of the button synchroniser. Must be >= 2.

Ports:
- clk, input, 1: system clock (the divided SOC clock).
- rst_n, input, 1: asynchronous active-low board reset.
- button_i, input, 1: raw pushbutton, active-high, asynchronous to `clk`.
- soc_rst_n, output, 1: active-low reset to the SOC.
- button_pressed, output, 1: one-cycle pulse on each accepted debounced press.
- reset_count, output, 8: number of button-triggered resets, saturating.

Behaviour:
- **Clock and reset.** One clock, `clk`. Reset `rst_n` is asynchronous, active-low. While `rst_n`=0, all state clears immediately:
  - `soc_rst_n`=0, `button_pressed`=0, `reset_count`=0
  - FSM=HOLD, counters=0, synchroniser and debounced level=0.
- **Reset release synchroniser.** `rst_sync_n` is a 2-flop chain asynchronously cleared by `rst_n` and fed with 1.
  - Release `rst_n` before edge 1: `rst_sync_n`=1 from edge 2.
- **Button synchroniser.** `button_i` passes through SYNC_STAGES flops to give `btn_s`.
- **Debounce.** Counter `db_cnt` against registered level `btn_db`:
  - If `btn_s`==`btn_db`: `db_cnt` clears to 0.
  - Otherwise `db_cnt` increments; on the edge where `db_cnt`==DEBOUNCE_CYCLES-1, `btn_db` takes `btn_s` and `db_cnt` clears.
  - A level must therefore differ for exactly DEBOUNCE_CYCLES consecutive cycles to be accepted. Any shorter glitch is discarded.
- **Press pulse.** `button_pressed` is asserted on the same edge that `btn_db` rises 0->1, for one cycle. No pulse is generated on the fall.
- **FSM states:**
  - HOLD: `soc_rst_n`=0. `hold_cnt` increments only while `rst_sync_n`=1. On the edge where `hold_cnt`==RESET_HOLD_CYCLES-1, go to RUN and set `soc_rst_n`=1 on that same edge.
  - RUN: `soc_rst_n`=1. On a `btn_db` rising edge, go to BUTTON and set `soc_rst_n`=0 on that same edge.
  - BUTTON: `soc_rst_n`=0 while `btn_db`=1. When `btn_db` falls, go to HOLD with `hold_cnt`=0.
- **Simultaneous events and boundaries:**
  - A `btn_db` rising edge while in HOLD goes to BUTTON and discards the `hold_cnt` progress.
  - `reset_count` increments on every entry to BUTTON, from either RUN or HOLD, and saturates at 255.
  - `reset_count` is cleared only by `rst_n`.
- **Latency:**
  - Power-on: `soc_rst_n` rises at edge 2+RESET_HOLD_CYCLES after `rst_n` release.
  - Button release: `soc_rst_n` rises SYNC_STAGES+DEBOUNCE_CYCLES+RESET_HOLD_CYCLES edges after the clean release.
- **Reset mid-operation.** `rst_n` low in any state forces `soc_rst_n`=0 with no clock required. A full power-on sequence follows the release.
- **Output glitches.** `soc_rst_n` is a direct flop output and must not glitch.

Test Plan (DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=8, SYNC_STAGES=2):
- **Power-on.** Hold `rst_n`=0 for 5 cycles, release before edge 1 -> `soc_rst_n`=0 through edge 9, =1 from edge 10; `reset_count`=0; no `button_pressed`.
- **Glitch rejection.** In RUN, drive `button_i`=1 for 3 cycles -> no `button_pressed`, `soc_rst_n` stays 1, `reset_count`=0.
- **Clean press.** In RUN, drive `button_i`=1 for 20 cycles, then 0 -> one `button_pressed` pulse; `soc_rst_n` falls on the same edge as the pulse, stays 0 while held, and returns to 1 exactly 2+4+8 edges after the falling edge of `button_i`; `reset_count`=1.
- **Press during HOLD.** Press again 3 cycles into HOLD -> FSM re-enters BUTTON, `hold_cnt` restarts from 0 after release (full 8 cycles), `reset_count`=2.
- **Async reset mid-BUTTON.** Pull `rst_n` low between clock edges -> `soc_rst_n`=0 and `reset_count`=0 before the next edge; the power-on timing of scenario 1 repeats after release.
- **Saturation.** Perform 300 clean presses -> `reset_count` reads 255 after press 255 and stays 255.
